// File: rtl/uart_rx_fifo.sv
// Purpose : receive-side byte FIFO for the UART receiver. It is first-word-fall-through with a sticky overrun flag.
// Latency : a byte strobed in cycle N shows on o_data in cycle N+1. There is no same-cycle bypass.
// Backpres: the receiver cannot be stalled. A strobe into a full FIFO is dropped and sets o_overflow,
//           unless a pop in the same cycle frees the slot.
//
// Ports:
//   i_clk, i_rst             clock; synchronous active-high reset
//   i_Rx_valid, i_Rx_data    single-cycle byte strobe from the receiver
//   o_valid, o_data, i_ready head-of-queue valid/ready handshake (o_data is 0 when empty)
//   o_count, o_empty, o_full occupancy, 0..DEPTH
//   o_overflow               sticky drop flag; i_clr_overflow pulse clears it (a drop wins)
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_Rx_valid,
  input  logic [DATA_W-1:0]     i_Rx_data,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_data,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  input  logic                  i_clr_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  // Pointers carry one extra bit so full and empty can be told apart
  // when the low index bits match.
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) && (wr_idx == rd_idx);

  assign pop  = !empty && i_ready;
  // When full, a pop in the same cycle frees the head slot, so the incoming
  // byte is accepted. The write lands on the slot being read out, which is
  // safe because the read happens combinationally before the edge.
  assign push = i_Rx_valid && (!full || pop);
  assign drop = i_Rx_valid && full && !pop;

  // Storage needs no reset: o_data is masked whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_idx] <= i_Rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overrun flag. A drop in the same cycle as a clear keeps it set,
  // so the consumer cannot miss the event that happened during the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
    end
  end

  assign o_count = wr_ptr - rd_ptr;
  assign o_empty = empty;
  assign o_full  = full;
  assign o_valid = !empty;
  assign o_data  = empty ? '0 : mem[rd_idx];

endmodule
